stage_queue: RTL and testbench

//   Multi-lane inter-stage queue: N-wide successor to the single-entry-per-cycle fifo between fetch, decode, map and rename.

---
 rtl/qu_common.sv | 20 ++
 rtl/lane_prefix_count.sv | 17 +
 rtl/stage_queue.sv | 127 ++++++++++++
 tb/tb_stage_queue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/qu_common.sv
// Shared lane constants and prefix-length helper for the inter-stage queues.
package qu_common;
  localparam int QU_FETCH_LANES  = 2;
  localparam int QU_DECODE_LANES = 2;
  localparam int QU_MAX_LANES    = 4;
  localparam int QU_LEN_W        = 3;

  // Number of consecutive 1s starting at bit 0.
  function automatic logic [QU_LEN_W-1:0] qu_prefix_len(input logic [QU_MAX_LANES-1:0] mask);
    logic [QU_LEN_W-1:0] n;
    logic                run;
    n   = '0;
    run = 1'b1;
    for (int i = 0; i < QU_MAX_LANES; i++) begin
      run = run & mask[i];
      if (run) n = n + QU_LEN_W'(1);
    end
    return n;
  endfunction
endpackage

// File: rtl/lane_prefix_count.sv
// Length of the contiguous run of set bits from bit 0 of a lane mask.
module lane_prefix_count
  import qu_common::*;
#(
  parameter int W = 2
) (
  input  logic [W-1:0]          mask,
  output logic [QU_LEN_W-1:0]   len
);
  logic [QU_MAX_LANES-1:0] mask_ext;

  always_comb begin
    mask_ext         = '0;
    mask_ext[W-1:0]  = mask;
    len              = qu_prefix_len(mask_ext);
  end
endmodule

// File: rtl/stage_queue.sv
// Multi-lane first-word-fall-through queue between front-end stages, flushable on branch.
// Optional occupancy statistics enabled by defining QU_STAGE_QUEUE_STATS_EN.
module stage_queue
  import qu_common::*;
#(
  parameter int ENTRY_WIDTH = 64,
  parameter int DEPTH       = 12,
  parameter int WR_LANES    = QU_FETCH_LANES,
  parameter int RD_LANES    = QU_DECODE_LANES
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [WR_LANES-1:0]             wr_valid,
  input  logic [WR_LANES*ENTRY_WIDTH-1:0] wr_data,
  output logic                            wr_ready,
  output logic [RD_LANES-1:0]             rd_valid,
  output logic [RD_LANES*ENTRY_WIDTH-1:0] rd_data,
  input  logic [RD_LANES-1:0]             rd_take,
  output logic [$clog2(DEPTH+1)-1:0]      count
`ifdef QU_STAGE_QUEUE_STATS_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]      peak_count,
  output logic [31:0]                     stall_cycles
`endif
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PW-1:0]          head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
  logic [ENTRY_WIDTH-1:0] mem_d [DEPTH];
  logic [QU_LEN_W-1:0]    wr_len, rd_len, n_wr, n_rd;

  // Wrap by subtraction so DEPTH need not be a power of two; k never exceeds DEPTH.
  function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  lane_prefix_count #(.W(WR_LANES)) u_wr_len (.mask(wr_valid),           .len(wr_len));
  lane_prefix_count #(.W(RD_LANES)) u_rd_len (.mask(rd_take & rd_valid), .len(rd_len));

  // Space check uses registered occupancy only; same-cycle pops do not free room.
  assign wr_ready = (DEPTH - int'(count_q)) >= WR_LANES;
  assign count    = count_q;

  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    for (int i = 0; i < RD_LANES; i++) begin
      if (int'(count_q) > i) begin
        rd_valid[i]                          = 1'b1;
        rd_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_q[ptr_add(head_q, i)];
      end
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    mem_d   = mem_q;
    n_wr    = '0;
    n_rd    = '0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      n_wr = wr_ready ? wr_len : '0;
      n_rd = rd_len;
      for (int i = 0; i < WR_LANES; i++)
        if (i < int'(n_wr)) mem_d[ptr_add(tail_q, i)] = wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH];
      head_d  = ptr_add(head_q, int'(n_rd));
      tail_d  = ptr_add(tail_q, int'(n_wr));
      count_d = CW'(int'(count_q) + int'(n_wr) - int'(n_rd));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
    mem_q <= mem_d;
  end

`ifdef QU_STAGE_QUEUE_STATS_EN
  logic [CW-1:0] peak_q, peak_d;
  logic [31:0]   stall_q, stall_d;

  always_comb begin
    peak_d  = (count_d > peak_q) ? count_d : peak_q;
    stall_d = stall_q;
    if (|wr_valid && !wr_ready && stall_q != '1) stall_d = stall_q + 32'd1;
  end

  // Flush leaves the statistics alone; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q  <= '0;
      stall_q <= '0;
    end else begin
      peak_q  <= peak_d;
      stall_q <= stall_d;
    end
  end

  assign peak_count   = peak_q;
  assign stall_cycles = stall_q;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(count_q) <= DEPTH);
  end
`endif
endmodule

// File: tb/tb_stage_queue.sv
// Scoreboard bench for stage_queue: queue-based reference model, directed cases then random traffic.
module tb_stage_queue;
  localparam int EW = 8;
  localparam int D  = 5;
  localparam int WL = 2;
  localparam int RL = 2;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [WL-1:0] wr_valid;
  logic [WL*EW-1:0] wr_data;
  logic          wr_ready;
  logic [RL-1:0] rd_valid;
  logic [RL*EW-1:0] rd_data;
  logic [RL-1:0] rd_take;
  logic [2:0]    count;
`ifdef QU_STAGE_QUEUE_STATS_EN
  logic [2:0]    peak_count;
  logic [31:0]   stall_cycles;
`endif

  always #5 clk = ~clk;

  stage_queue #(.ENTRY_WIDTH(EW), .DEPTH(D), .WR_LANES(WL), .RD_LANES(RL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_take(rd_take),
    .count(count)
`ifdef QU_STAGE_QUEUE_STATS_EN
    , .peak_count(peak_count), .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    int        cnt;
    bit        rdy;
    bit [1:0]  vld;
    bit [15:0] dat;
    int        peak;
    int        stall;
  } snap_t;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] mdl[$];
  int         m_peak = 0;
  int         m_stall = 0;
  snap_t      exp_q[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic snap_t snap();
    snap_t s;
    s.cnt = mdl.size();
    s.rdy = (D - mdl.size()) >= WL;
    s.vld = '0;
    s.dat = '0;
    for (int i = 0; i < RL; i++) begin
      if (i < mdl.size()) begin
        s.vld[i]        = 1'b1;
        s.dat[i*EW +: EW] = mdl[i];
      end
    end
    s.peak  = m_peak;
    s.stall = m_stall;
    return s;
  endfunction

  // One clock of stimulus: record what the DUT should show now, drive, advance the model.
  task automatic step(input bit fl, input bit [1:0] wv, input bit [15:0] wd, input bit [1:0] tk);
    int sz, nrd, nwr;
    bit rdy;
    exp_q.push_back(snap());
    flush = fl; wr_valid = wv; wr_data = wd; rd_take = tk;
    sz  = mdl.size();
    rdy = (D - sz) >= WL;
    if (wv != 2'b00 && !rdy) m_stall++;
    if (fl) mdl.delete();
    else begin
      nrd = 0;
      for (int i = 0; i < RL; i++) begin
        if (tk[i] && i < sz) nrd++;
        else break;
      end
      nwr = 0;
      if (rdy)
        for (int i = 0; i < WL; i++) begin
          if (wv[i]) nwr++;
          else break;
        end
      repeat (nrd) void'(mdl.pop_front());
      for (int i = 0; i < nwr; i++) mdl.push_back(wd[i*EW +: EW]);
    end
    if (mdl.size() > m_peak) m_peak = mdl.size();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    snap_t s;
    if (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      chk("count", 64'(count), 64'(s.cnt));
      chk("wr_ready", 64'(wr_ready), 64'(s.rdy));
      chk("rd_valid", 64'(rd_valid), 64'(s.vld));
      chk("rd_data", 64'(rd_data), 64'(s.dat));
`ifdef QU_STAGE_QUEUE_STATS_EN
      chk("peak_count", 64'(peak_count), 64'(s.peak));
      chk("stall_cycles", 64'(stall_cycles), 64'(s.stall));
`endif
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; wr_valid = '0; wr_data = '0; rd_take = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    chk("reset_rd_data", 64'(rd_data), 64'd0);
    chk("reset_wr_ready", 64'(wr_ready), 64'd1);

    // Fill to 4, then a blocked write
    step(0, 2'b11, 16'hA1A0, 2'b00);
    step(0, 2'b11, 16'hA3A2, 2'b00);
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_wr_ready", 64'(wr_ready), 64'd0);
    chk("fill_lane0", 64'(rd_data[7:0]), 64'hA0);
    chk("fill_lane1", 64'(rd_data[15:8]), 64'hA1);
    step(0, 2'b11, 16'hB1B0, 2'b00);
    chk("blocked_count", 64'(count), 64'd4);
    chk("blocked_lane0", 64'(rd_data[7:0]), 64'hA0);

    // Drain and write across the wrap point
    step(0, 2'b00, 16'h0000, 2'b11);
    step(0, 2'b00, 16'h0000, 2'b11);
    chk("drain_count", 64'(count), 64'd0);
    step(0, 2'b11, 16'hC1C0, 2'b00);
    chk("wrap_count", 64'(count), 64'd2);
    chk("wrap_lane0", 64'(rd_data[7:0]), 64'hC0);
    chk("wrap_lane1", 64'(rd_data[15:8]), 64'hC1);

    // Simultaneous push and pop at count 3
    step(0, 2'b01, 16'h00E0, 2'b00);
    chk("single_count", 64'(count), 64'd3);
    step(0, 2'b11, 16'hD1D0, 2'b11);
    chk("simul_count", 64'(count), 64'd3);
    chk("simul_lane0", 64'(rd_data[7:0]), 64'hE0);
    chk("simul_lane1", 64'(rd_data[15:8]), 64'hD0);
    step(0, 2'b00, 16'h0000, 2'b01);
    chk("behind_lane0", 64'(rd_data[7:0]), 64'hD0);
    chk("behind_lane1", 64'(rd_data[15:8]), 64'hD1);

    // Non-prefix masks
    step(0, 2'b10, 16'hF1F0, 2'b00);
    chk("wmask_count", 64'(count), 64'd2);
    step(0, 2'b00, 16'h0000, 2'b10);
    chk("tmask_count", 64'(count), 64'd2);
    chk("tmask_lane0", 64'(rd_data[7:0]), 64'hD0);

    // Flush beats concurrent write and take
    step(0, 2'b11, 16'h9190, 2'b00);
    chk("preflush_count", 64'(count), 64'd4);
    step(1, 2'b11, 16'h8180, 2'b11);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_rd_valid", 64'(rd_valid), 64'd0);
    chk("flush_rd_data", 64'(rd_data), 64'd0);
    chk("flush_wr_ready", 64'(wr_ready), 64'd1);
`ifdef QU_STAGE_QUEUE_STATS_EN
    chk("flush_peak", 64'(peak_count), 64'd4);
    chk("flush_stall", 64'(stall_cycles), 64'd2);
`endif

    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) begin
        rst = 1'b1; flush = 1'b0; wr_valid = '0; rd_take = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl.delete(); m_peak = 0; m_stall = 0;
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_rd_valid", 64'(rd_valid), 64'd0);
      end
      step($urandom_range(0, 24) == 0, 2'($urandom), 16'($urandom), 2'($urandom));
    end
    step(0, 2'b00, 16'h0000, 2'b00);

    for (int g = 0; g < 10 && exp_q.size() > 0; g++) @(posedge clk);
    if (exp_q.size() > 0) chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
